matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ADDR_W, default 12, data-memory address width.
REQ-002 Parameter MEM_LAT, default 2, fixed data-memory read latency in cycles (equals the PE capture slot latency_counter==2).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START  in  1  single-cycle load request; sampled only in IDLE.
REQ-006 SEL  in  2  01=load A only, 10=load B only, 11=load A then B, 00=no load.
REQ-007 DIMEN  in  2  elements per matrix = 2^(DIMEN+1) (2/4/8/16); sampled at START.
REQ-008 BASE_A / BASE_B  in  ADDR_W each  start addresses of A / B; sampled at START.
REQ-009 MEM_RD  out  1  read strobe to data memory.
REQ-010 MEM_ADDR  out  ADDR_W  read address, valid while MEM_RD=1.
REQ-011 MEM_DATA  in  32  read data, valid exactly MEM_LAT cycles after MEM_RD.
REQ-012 DATAIN  out  32  element word to PE array.
REQ-013 WRITE_MAT  out  1  PE write-enable window.
REQ-014 MAT_MUX  out  1  1=target MATA, 0=target MATB.
REQ-015 RST_ADD  out  1  one-cycle PE address-pointer clear.
REQ-016 latency_counter  out  3  element phase 0..2.
REQ-017 BUSY  out  1  high in any state other than IDLE.
REQ-018 DONE  out  1  one-cycle completion pulse.

Function
REQ-019 The block SHALL implement states IDLE, CLR, FETCH, FIN.
REQ-020 IDLE: on START=1 with SEL!=00, SHALL latch SEL, DIMEN, BASE_A, BASE_B and go to CLR; with SEL=00, SHALL go directly to FIN.
REQ-021 CLR: SHALL drive RST_ADD=1 for exactly one cycle, set MAT_MUX for the current matrix (A first when SEL=11), clear element index and phase, then go to FETCH.
REQ-022 FETCH: each element SHALL take exactly 3 cycles, latency_counter=0,1,2 in turn.
REQ-023 Phase 0: MEM_RD=1, MEM_ADDR=base+index (modulo 2^ADDR_W, wrap without error); phases 1,2: MEM_RD=0.
REQ-024 Phase 2: DATAIN SHALL equal MEM_DATA; in all other cycles DATAIN SHALL be 0.
REQ-025 WRITE_MAT SHALL be 1 throughout FETCH and 0 elsewhere; MAT_MUX SHALL stay constant for a whole matrix.
REQ-026 After phase 2 of the last element (index=2^(DIMEN+1)-1): if SEL=11 and A just finished, SHALL go to CLR for B (MAT_MUX=0, base=BASE_B); otherwise to FIN.
REQ-027 FIN: DONE=1 for one cycle, then IDLE.
REQ-028 START while BUSY=1 SHALL be ignored; latched inputs SHALL not change mid-load.
REQ-029 Element index SHALL be 5 bits so that 16 elements are counted without overflow.
REQ-030 Per matrix, total cycles = 1 (CLR) + 3*2^(DIMEN+1); SEL=11 doubles this; plus 1 FIN cycle.

Reset
REQ-031 While RST=1 the block SHALL enter IDLE and hold MEM_RD, WRITE_MAT, RST_ADD, DONE, BUSY=0, DATAIN=0, MEM_ADDR=0, latency_counter=0, MAT_MUX=0.
REQ-032 RST asserted mid-load SHALL abort immediately with no DONE pulse; RST and START together SHALL give reset priority.

Verification
REQ-033 DIMEN=0, SEL=01, BASE_A=0x100, START at cycle 0 -> cycle 1 RST_ADD=1; MEM_RD at cycles 2,5 with addr 0x100,0x101; DATAIN=mem data at cycles 4,7 with latency_counter=2, MAT_MUX=1; DONE at cycle 8.
REQ-034 DIMEN=3, SEL=11, BASE_A=0x000, BASE_B=0x040 -> 16 reads 0x000..0x00F, MAT_MUX=1, second RST_ADD pulse, 16 reads 0x040..0x04F, MAT_MUX=0, DONE after 2*(1+48)+1 cycles; PE model ends holding matching MATA/MATB.
REQ-035 BASE_A=0xFFE, DIMEN=1 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-036 SEL=00 START -> DONE one cycle later, no MEM_RD, no RST_ADD.
REQ-037 START pulsed again during FETCH -> ignored, one DONE only; RST at element 3 of 8 -> all outputs 0 next cycle, no DONE, fresh START then completes normally.

Source files
------------

// File: rtl/matrix_loader.sv
// Streams one or two square matrices from data memory into the PE array.
// Each element takes one read cycle plus MEM_LAT wait cycles; the PE captures on the last phase.
module matrix_loader #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        SEL,
    input  logic [1:0]        DIMEN,
    input  logic [ADDR_W-1:0] BASE_A,
    input  logic [ADDR_W-1:0] BASE_B,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [31:0]       MEM_DATA,
    output logic [31:0]       DATAIN,
    output logic              WRITE_MAT,
    output logic              MAT_MUX,
    output logic              RST_ADD,
    output logic [2:0]        latency_counter,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {StIdle, StClr, StFetch, StFin} state_e;

    localparam logic [2:0] LastPhase = 3'(MEM_LAT);

    state_e            state_q;
    logic [1:0]        sel_q;
    logic [1:0]        dimen_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [4:0]        idx_q;

    logic [ADDR_W-1:0] cur_base;
    logic              last_elem;

    // MAT_MUX is set on entry to CLR, so it already selects the matrix being fetched.
    assign cur_base  = MAT_MUX ? base_a_q : base_b_q;
    assign last_elem = (idx_q == ((5'd2 << dimen_q) - 5'd1));

    // Read data is only meaningful in the capture phase; mask it everywhere else.
    assign DATAIN = (state_q == StFetch && latency_counter == LastPhase) ? MEM_DATA : 32'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= StIdle;
            sel_q           <= '0;
            dimen_q         <= '0;
            base_a_q        <= '0;
            base_b_q        <= '0;
            idx_q           <= '0;
            MEM_RD          <= 1'b0;
            MEM_ADDR        <= '0;
            WRITE_MAT       <= 1'b0;
            MAT_MUX         <= 1'b0;
            RST_ADD         <= 1'b0;
            latency_counter <= '0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
        end else begin
            RST_ADD <= 1'b0;
            DONE    <= 1'b0;
            MEM_RD  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        BUSY <= 1'b1;
                        if (SEL != 2'b00) begin
                            sel_q    <= SEL;
                            dimen_q  <= DIMEN;
                            base_a_q <= BASE_A;
                            base_b_q <= BASE_B;
                            MAT_MUX  <= SEL[0];
                            RST_ADD  <= 1'b1;
                            state_q  <= StClr;
                        end else begin
                            DONE    <= 1'b1;
                            state_q <= StFin;
                        end
                    end
                end
                StClr: begin
                    idx_q           <= '0;
                    latency_counter <= '0;
                    MEM_RD          <= 1'b1;
                    MEM_ADDR        <= cur_base;
                    WRITE_MAT       <= 1'b1;
                    state_q         <= StFetch;
                end
                StFetch: begin
                    if (latency_counter != LastPhase) begin
                        latency_counter <= latency_counter + 3'd1;
                    end else begin
                        latency_counter <= '0;
                        if (!last_elem) begin
                            idx_q    <= idx_q + 5'd1;
                            MEM_RD   <= 1'b1;
                            MEM_ADDR <= cur_base + ADDR_W'(idx_q + 5'd1);
                        end else begin
                            WRITE_MAT <= 1'b0;
                            if (sel_q == 2'b11 && MAT_MUX) begin
                                MAT_MUX <= 1'b0;
                                RST_ADD <= 1'b1;
                                state_q <= StClr;
                            end else begin
                                DONE    <= 1'b1;
                                state_q <= StFin;
                            end
                        end
                    end
                end
                StFin: begin
                    BUSY    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: a per-cycle expected trace is built from the load rules and compared
// against the DUT; a latency-2 memory and a small PE capture model sit around it.
module tb_matrix_loader;

    logic        CLK = 1'b0;
    logic        RST, START;
    logic [1:0]  SEL, DIMEN;
    logic [11:0] BASE_A, BASE_B, MEM_ADDR;
    logic        MEM_RD, WRITE_MAT, MAT_MUX, RST_ADD, BUSY, DONE;
    logic [31:0] MEM_DATA, DATAIN;
    logic [2:0]  latency_counter;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_loader #(.ADDR_W(12), .MEM_LAT(2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SEL(SEL), .DIMEN(DIMEN),
        .BASE_A(BASE_A), .BASE_B(BASE_B), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA(MEM_DATA), .DATAIN(DATAIN), .WRITE_MAT(WRITE_MAT), .MAT_MUX(MAT_MUX),
        .RST_ADD(RST_ADD), .latency_counter(latency_counter), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Data memory: word read at cycle n is presented during cycle n+2; junk otherwise.
    logic [31:0] mem [4096];
    logic        p1_v = 1'b0;
    logic [11:0] p1_a = '0;
    always @(posedge CLK) begin
        p1_v     <= MEM_RD;
        p1_a     <= MEM_ADDR;
        MEM_DATA <= p1_v ? mem[p1_a] : $urandom;
    end

    // PE array model: pointer cleared by RST_ADD, one word captured per element.
    logic [31:0] pe_a [16];
    logic [31:0] pe_b [16];
    int          pe_ptr = 0;
    always @(negedge CLK) begin
        if (RST_ADD) pe_ptr = 0;
        else if (WRITE_MAT && latency_counter == 3'd2) begin
            if (MAT_MUX) pe_a[pe_ptr % 16] = DATAIN;
            else         pe_b[pe_ptr % 16] = DATAIN;
            pe_ptr++;
        end
    end

    typedef struct {
        bit        busy, done, rst_add, write_mat, mat_mux, chk_mux, mem_rd;
        bit [2:0]  lc;
        bit [11:0] addr;
        bit [31:0] datain;
    } rec_t;

    rec_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_model(input logic [1:0] sel, input logic [1:0] dimen,
                               input logic [11:0] ba, input logic [11:0] bb);
        rec_t r;
        int   n;
        exp_q.delete();
        n = 2 << dimen;
        for (int m = 0; m < 2; m++) begin
            logic [11:0] base;
            if (!sel[m]) continue;
            base = (m == 0) ? ba : bb;
            r = '{default: 0};
            r.busy = 1; r.rst_add = 1; r.mat_mux = (m == 0); r.chk_mux = 1;
            exp_q.push_back(r);
            for (int i = 0; i < n; i++) begin
                for (int p = 0; p < 3; p++) begin
                    r = '{default: 0};
                    r.busy = 1; r.write_mat = 1; r.mat_mux = (m == 0); r.chk_mux = 1;
                    r.mem_rd = (p == 0);
                    r.lc     = 3'(p);
                    r.addr   = base + 12'(i);
                    r.datain = (p == 2) ? mem[base + 12'(i)] : 32'd0;
                    exp_q.push_back(r);
                end
            end
        end
        r = '{default: 0};
        r.busy = 1; r.done = 1;
        exp_q.push_back(r);
        r = '{default: 0};
        exp_q.push_back(r);
    endtask

    task automatic check_zero(input string tag);
        check_eq(tag, 64'({BUSY, DONE, RST_ADD, WRITE_MAT, MAT_MUX, MEM_RD, latency_counter,
                           MEM_ADDR, DATAIN}), 64'd0);
    endtask

    // restart_at >= 0 re-pulses START during the load; abort_at >= 0 asserts RST after that record.
    task automatic run_load(input logic [1:0] sel, input logic [1:0] dimen,
                            input logic [11:0] ba, input logic [11:0] bb,
                            input int restart_at, input int abort_at);
        int done_cyc = 0;
        int exp_cyc;
        int rs;
        build_model(sel, dimen, ba, bb);
        rs = (restart_at >= 0) ? restart_at % (exp_q.size() - 1) : -1;
        exp_cyc = (sel == 2'b00) ? 1 : (int'(sel[0]) + int'(sel[1])) * (1 + 3 * (2 << dimen)) + 1;
        @(negedge CLK);
        SEL = sel; DIMEN = dimen; BASE_A = ba; BASE_B = bb; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        SEL = 2'($urandom); DIMEN = 2'($urandom); BASE_A = 12'($urandom); BASE_B = 12'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            rec_t e;
            if (i > 0) @(negedge CLK);
            START = 1'b0;
            e = exp_q[i];
            check_eq($sformatf("ctrl[%0d]", i),
                     64'({BUSY, DONE, RST_ADD, WRITE_MAT, MEM_RD, latency_counter}),
                     64'({e.busy, e.done, e.rst_add, e.write_mat, e.mem_rd, e.lc}));
            check_eq($sformatf("datain[%0d]", i), 64'(DATAIN), 64'(e.datain));
            if (e.chk_mux) check_eq($sformatf("mux[%0d]", i), 64'(MAT_MUX), 64'(e.mat_mux));
            if (e.mem_rd)  check_eq($sformatf("addr[%0d]", i), 64'(MEM_ADDR), 64'(e.addr));
            if (DONE && done_cyc == 0) done_cyc = i + 1;
            if (i == rs) START = 1'b1;
            if (i == abort_at) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                check_zero("abort_outs");
                @(negedge CLK);
                check_eq("abort_no_done", 64'({BUSY, DONE}), 64'd0);
                return;
            end
        end
        check_eq("done_cycle", 64'(done_cyc), 64'(exp_cyc));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        RST = 1'b1; START = 1'b0; SEL = '0; DIMEN = '0; BASE_A = '0; BASE_B = '0;
        repeat (3) @(negedge CLK);
        check_zero("reset_state");
        RST = 1'b0;

        // Single A load, 2 elements.
        run_load(2'b01, 2'd0, 12'h100, 12'h000, -1, -1);
        // A then B, 16 elements each, then PE contents.
        run_load(2'b11, 2'd3, 12'h000, 12'h040, -1, -1);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("pe_a[%0d]", i), 64'(pe_a[i]), 64'(mem[i]));
            check_eq($sformatf("pe_b[%0d]", i), 64'(pe_b[i]), 64'(mem[12'h040 + i]));
        end
        // Address wrap.
        run_load(2'b01, 2'd1, 12'hFFE, 12'h000, -1, -1);
        // No-load request.
        run_load(2'b00, 2'd2, 12'h123, 12'h456, -1, -1);
        // START during FETCH ignored.
        run_load(2'b10, 2'd2, 12'h200, 12'h300, 7, -1);
        // Reset at element 3 of 8, then a fresh load.
        run_load(2'b01, 2'd2, 12'h500, 12'h600, -1, 10);
        run_load(2'b01, 2'd2, 12'h500, 12'h600, -1, -1);

        // Reset has priority over START.
        @(negedge CLK);
        RST = 1'b1; START = 1'b1; SEL = 2'b11;
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        check_zero("rst_start_prio");
        @(negedge CLK);
        check_eq("rst_start_idle", 64'({BUSY, DONE}), 64'd0);

        for (int k = 0; k < 14; k++) begin
            run_load(2'($urandom), 2'($urandom), 12'($urandom), 12'($urandom),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
